device_arbiter_n: RTL and testbench



---
 rtl/device_arbiter_n.sv | 152 +++++++++++++++
 tb/tb_device_arbiter_n.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/device_arbiter_n.sv
// device_arbiter_n: merges NUM_CHANNELS bank-tagged request ports onto one device port,
// using a fixed-priority or round-robin grant and an in-order read-tag FIFO for acks.
module device_arbiter_n #(
   parameter int         NUM_CHANNELS   = 4,
   parameter logic [3:0] DEVICE_BANK    = 4'd0,
   parameter int         ADDRESS_WIDTH  = 26,
   parameter int         DATA_WIDTH     = 32,
   parameter int         ACK_FIFO_DEPTH = 4,
   parameter bit         ROUND_ROBIN    = 1'b1
) (
   input  logic                                  i_clk,
   input  logic                                  i_reset,
   input  logic [NUM_CHANNELS-1:0]               i_ch_request,
   input  logic [NUM_CHANNELS-1:0]               i_ch_write,
   input  logic [4*NUM_CHANNELS-1:0]             i_ch_bank,
   input  logic [ADDRESS_WIDTH*NUM_CHANNELS-1:0] i_ch_address,
   input  logic [DATA_WIDTH*NUM_CHANNELS-1:0]    i_ch_data,
   output logic [NUM_CHANNELS-1:0]               o_ch_busy,
   output logic [NUM_CHANNELS-1:0]               o_ch_ack,
   output logic [DATA_WIDTH-1:0]                 o_ch_data,
   output logic                                  o_request,
   output logic                                  o_write,
   input  logic                                  i_busy,
   input  logic                                  i_ack,
   output logic [ADDRESS_WIDTH-1:0]              o_address,
   input  logic [DATA_WIDTH-1:0]                 i_data,
   output logic [DATA_WIDTH-1:0]                 o_data
);

   localparam int              CW        = $clog2(NUM_CHANNELS);
   localparam int              FW        = $clog2(ACK_FIFO_DEPTH);
   localparam logic [CW-1:0]   PTR_RESET = CW'(NUM_CHANNELS - 1);
   localparam logic [FW:0]     FIFO_FULL = (FW+1)'(ACK_FIFO_DEPTH);

   logic [NUM_CHANNELS-1:0]  eligible_s;
   logic [ADDRESS_WIDTH-1:0] ch_addr_s [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]    ch_data_s [NUM_CHANNELS];
   logic [CW-1:0]            grant_s;
   logic                     any_s;
   logic                     blocked_s;
   logic                     issue_s;
   logic                     push_s;
   logic                     pop_s;
   logic                     fifo_full_s;
   logic                     fifo_empty_s;
   logic [CW-1:0]            head_s;

   logic [CW-1:0]            ptr_r;
   logic [CW-1:0]            tag_mem_r [ACK_FIFO_DEPTH];
   logic [FW-1:0]            wr_ptr_r;
   logic [FW-1:0]            rd_ptr_r;
   logic [FW:0]              count_r;

   // Scanning from the highest offset down lets the nearest eligible channel win last.
   function automatic logic [CW-1:0] pick_grant(input logic [NUM_CHANNELS-1:0] elig,
                                                input logic [CW-1:0]           last);
      logic [CW-1:0] g;
      logic [CW-1:0] idx;
      g = {CW{1'b0}};
      for (int i = NUM_CHANNELS; i >= 1; i--) begin
         if (ROUND_ROBIN) begin
            idx = CW'((int'(last) + i) % NUM_CHANNELS);
         end else begin
            idx = CW'(i - 1);
         end
         g = elig[idx] ? idx : g;
      end
      return g;
   endfunction

   // Unpack per-channel buses and match each request against this bank
   always_comb begin
      eligible_s = {NUM_CHANNELS{1'b0}};
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         eligible_s[k] = i_ch_request[k] && (i_ch_bank[4*k +: 4] == DEVICE_BANK);
         ch_addr_s[k]  = i_ch_address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
         ch_data_s[k]  = i_ch_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Tag FIFO status; full is judged before any same-cycle pop
   always_comb begin
      fifo_full_s  = (count_r == FIFO_FULL);
      fifo_empty_s = (count_r == {(FW+1){1'b0}});
      head_s       = tag_mem_r[rd_ptr_r];
      pop_s        = i_ack && !fifo_empty_s;
      o_ch_ack     = {NUM_CHANNELS{1'b0}};
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         o_ch_ack[k] = pop_s && (head_s == CW'(k));
      end
   end

   assign o_ch_data = i_data;

   // Grant, device-side mux and per-channel busy
   always_comb begin
      any_s     = |eligible_s;
      grant_s   = pick_grant(eligible_s, ptr_r);
      blocked_s = any_s && !i_ch_write[grant_s] && fifo_full_s;
      o_request = any_s && !blocked_s && !i_reset;
      issue_s   = o_request && !i_busy;
      if (any_s) begin
         o_write   = i_ch_write[grant_s];
         o_address = ch_addr_s[grant_s];
         o_data    = ch_data_s[grant_s];
      end else begin
         o_write   = 1'b0;
         o_address = {ADDRESS_WIDTH{1'b0}};
         o_data    = {DATA_WIDTH{1'b0}};
      end
      push_s    = issue_s && !o_write;
      o_ch_busy = {NUM_CHANNELS{1'b0}};
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         o_ch_busy[k] = eligible_s[k] && !((CW'(k) == grant_s) && issue_s);
      end
   end

   // Round-robin pointer follows the last issued channel
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ptr_r <= PTR_RESET;
      end else if (issue_s) begin
         ptr_r <= grant_s;
      end
   end

   // Read-tag FIFO storage, pointers and occupancy
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < ACK_FIFO_DEPTH; i++) begin
            tag_mem_r[i] <= {CW{1'b0}};
         end
         wr_ptr_r <= {FW{1'b0}};
         rd_ptr_r <= {FW{1'b0}};
         count_r  <= {(FW+1){1'b0}};
      end else begin
         if (push_s) begin
            tag_mem_r[wr_ptr_r] <= grant_s;
            wr_ptr_r            <= wr_ptr_r + FW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + FW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (FW+1)'(1);
            2'b01:   count_r <= count_r - (FW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_device_arbiter_n.sv
// Bench for device_arbiter_n: a round-robin and a fixed-priority instance share stimulus
// and are checked every cycle against a queue-based model, plus directed literal checks.
module tb_device_arbiter_n;

   localparam int N  = 4;
   localparam int AW = 26;
   localparam int DW = 32;
   localparam int D  = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    ch_req, ch_wr;
   logic [4*N-1:0]  ch_bank;
   logic [AW*N-1:0] ch_addr;
   logic [DW*N-1:0] ch_data;
   logic            dev_busy, dev_ack;
   logic [DW-1:0]   dev_rdata;

   // index 0 = round-robin instance, index 1 = fixed-priority instance
   logic [N-1:0]    o_busy [2];
   logic [N-1:0]    o_ack [2];
   logic [DW-1:0]   o_chdata [2];
   logic            o_req [2];
   logic            o_wr [2];
   logic [AW-1:0]   o_addr [2];
   logic [DW-1:0]   o_wdata [2];

   int errors = 0;
   int checks = 0;

   int q [2][$];
   int rr_ptr = N - 1;
   bit m_push [2] = '{1'b0, 1'b0};
   bit m_pop [2]  = '{1'b0, 1'b0};
   bit m_issue [2] = '{1'b0, 1'b0};
   int m_g [2] = '{0, 0};

   always #5 clk = ~clk;

   device_arbiter_n #(.NUM_CHANNELS(N), .DEVICE_BANK(4'd0), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                      .ACK_FIFO_DEPTH(D), .ROUND_ROBIN(1'b1)) dut_rr (
      .i_clk(clk), .i_reset(rst), .i_ch_request(ch_req), .i_ch_write(ch_wr), .i_ch_bank(ch_bank),
      .i_ch_address(ch_addr), .i_ch_data(ch_data), .o_ch_busy(o_busy[0]), .o_ch_ack(o_ack[0]),
      .o_ch_data(o_chdata[0]), .o_request(o_req[0]), .o_write(o_wr[0]), .i_busy(dev_busy),
      .i_ack(dev_ack), .o_address(o_addr[0]), .i_data(dev_rdata), .o_data(o_wdata[0]));

   device_arbiter_n #(.NUM_CHANNELS(N), .DEVICE_BANK(4'd0), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                      .ACK_FIFO_DEPTH(D), .ROUND_ROBIN(1'b0)) dut_fx (
      .i_clk(clk), .i_reset(rst), .i_ch_request(ch_req), .i_ch_write(ch_wr), .i_ch_bank(ch_bank),
      .i_ch_address(ch_addr), .i_ch_data(ch_data), .o_ch_busy(o_busy[1]), .o_ch_ack(o_ack[1]),
      .o_ch_data(o_chdata[1]), .o_request(o_req[1]), .o_write(o_wr[1]), .i_busy(dev_busy),
      .i_ack(dev_ack), .o_address(o_addr[1]), .i_data(dev_rdata), .o_data(o_wdata[1]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference: outputs derived from the arbitration rules and a queue of outstanding read tags
   task automatic model_check(input int d);
      logic [N-1:0]  el, exp_busy, exp_ack;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wd;
      int            g;
      bit            found, any, blk, req, iss, wr;
      string         tag;
      tag = (d == 0) ? "rr" : "fx";
      for (int k = 0; k < N; k++) el[k] = ch_req[k] && (ch_bank[4*k +: 4] == 4'd0);
      any = (el != 4'b0000);
      found = 1'b0;
      g = 0;
      for (int j = 0; j < N; j++) begin
         int c;
         c = (d == 0) ? (rr_ptr + 1 + j) % N : j;
         if (!found && el[c]) begin
            g = c;
            found = 1'b1;
         end
      end
      wr  = any ? ch_wr[g] : 1'b0;
      blk = any && !ch_wr[g] && (q[d].size() == D);
      req = any && !blk && !rst;
      iss = req && !dev_busy;
      exp_busy = el;
      if (iss) exp_busy[g] = 1'b0;
      exp_ack = 4'b0000;
      if (dev_ack && q[d].size() > 0) exp_ack[q[d][0]] = 1'b1;
      exp_addr = any ? ch_addr[AW*g +: AW] : '0;
      exp_wd   = any ? ch_data[DW*g +: DW] : '0;
      chk({tag, " o_request"}, 64'(o_req[d]), 64'(req));
      chk({tag, " o_write"},   64'(o_wr[d]), 64'(wr));
      chk({tag, " o_address"}, 64'(o_addr[d]), 64'(exp_addr));
      chk({tag, " o_data"},    64'(o_wdata[d]), 64'(exp_wd));
      chk({tag, " o_ch_busy"}, 64'(o_busy[d]), 64'(exp_busy));
      chk({tag, " o_ch_ack"},  64'(o_ack[d]), 64'(exp_ack));
      chk({tag, " o_ch_data"}, 64'(o_chdata[d]), 64'(dev_rdata));
      m_issue[d] = iss;
      m_push[d]  = iss && !ch_wr[g];
      m_pop[d]   = dev_ack && (q[d].size() > 0);
      m_g[d]     = g;
   endtask

   always @(negedge clk) begin
      model_check(0);
      model_check(1);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) q[d].delete();
         rr_ptr <= N - 1;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (m_pop[d]) void'(q[d].pop_front());
            if (m_push[d]) q[d].push_back(m_g[d]);
         end
         if (m_issue[0]) rr_ptr <= m_g[0];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ch_req = '0; ch_wr = '0; ch_bank = '0; ch_addr = '0; ch_data = '0;
      dev_busy = 1'b0; dev_ack = 1'b0; dev_rdata = '0;
   endtask

   task automatic set_ch(input int k, input logic wr, input logic [3:0] bank);
      ch_req[k] = 1'b1;
      ch_wr[k] = wr;
      ch_bank[4*k +: 4] = bank;
      ch_addr[AW*k +: AW] = AW'(100 + k);
      ch_data[DW*k +: DW] = DW'(32'hD0 + k);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int gseq [8] = '{0, 1, 2, 3, 3, 3, 3, 0};
      logic [3:0] aseq [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0000};
      logic [3:0] eb;

      // Reset: busy mirrors eligibility, no request, no ack
      rst = 1'b1;
      clear_inputs();
      set_ch(0, 1'b0, 4'd0);
      dev_ack = 1'b1;
      tick(); #3;
      chk("reset o_request", 64'(o_req[0]), 64'd0);
      chk("reset o_ch_busy", 64'(o_busy[0]), 64'h1);
      chk("reset o_ch_ack", 64'(o_ack[0]), 64'd0);
      tick();
      rst = 1'b0;
      clear_inputs();
      #3;
      chk("idle o_request", 64'(o_req[0]), 64'd0);
      tick();

      // Fixed priority: channels 1 and 3 read continuously, channel 1 always wins
      set_ch(1, 1'b0, 4'd0);
      set_ch(3, 1'b0, 4'd0);
      dev_ack = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #3;
         chk("fixed o_ch_busy", 64'(o_busy[1]), 64'h8);
         chk("fixed o_address", 64'(o_addr[1]), 64'd101);
         chk("fixed o_ch_ack", 64'(o_ack[1]), (i == 0) ? 64'h0 : 64'h2);
         tick();
      end

      // Round-robin writes from all channels, with the device busy for 3 cycles
      do_reset();
      for (int k = 0; k < N; k++) set_ch(k, 1'b1, 4'd0);
      for (int i = 0; i < 8; i++) begin
         dev_busy = (i >= 3 && i <= 5);
         eb = dev_busy ? 4'hF : (4'hF & ~(4'b0001 << gseq[i]));
         #3;
         chk("rr o_request", 64'(o_req[0]), 64'd1);
         chk("rr o_address", 64'(o_addr[0]), 64'(100 + gseq[i]));
         chk("rr o_data", 64'(o_wdata[0]), 64'(32'hD0 + gseq[i]));
         chk("rr o_ch_busy", 64'(o_busy[0]), 64'(eb));
         tick();
      end

      // Foreign bank is ignored
      clear_inputs();
      set_ch(2, 1'b0, 4'd5);
      #3;
      chk("bank o_ch_busy", 64'(o_busy[0]), 64'd0);
      chk("bank o_request", 64'(o_req[0]), 64'd0);
      chk("bank fx o_request", 64'(o_req[1]), 64'd0);
      tick();

      // Full tag FIFO blocks reads but not writes; ack does not unblock the same cycle
      do_reset();
      set_ch(0, 1'b0, 4'd0);
      for (int i = 0; i < 4; i++) begin
         #3;
         chk("fill o_request", 64'(o_req[0]), 64'd1);
         tick();
      end
      #3;
      chk("full o_request", 64'(o_req[0]), 64'd0);
      chk("full o_ch_busy", 64'(o_busy[0]), 64'h1);
      tick();
      set_ch(1, 1'b1, 4'd0);
      #3;
      chk("full wr o_request", 64'(o_req[0]), 64'd1);
      chk("full wr o_write", 64'(o_wr[0]), 64'd1);
      chk("full wr o_address", 64'(o_addr[0]), 64'd101);
      chk("full wr o_ch_busy", 64'(o_busy[0]), 64'h1);
      tick();
      ch_req[1] = 1'b0;
      dev_ack = 1'b1;
      #3;
      chk("full ack o_request", 64'(o_req[0]), 64'd0);
      chk("full ack o_ch_busy", 64'(o_busy[0]), 64'h1);
      chk("full ack o_ch_ack", 64'(o_ack[0]), 64'h1);
      tick();
      dev_ack = 1'b0;
      #3;
      chk("unblock o_request", 64'(o_req[0]), 64'd1);
      chk("unblock o_ch_busy", 64'(o_busy[0]), 64'h0);
      tick();

      // Acks route back in issue order: 2, 0, 2, then an ack with nothing outstanding
      do_reset();
      set_ch(2, 1'b0, 4'd0);
      #3;
      chk("tag o_request", 64'(o_req[0]), 64'd1);
      tick();
      clear_inputs(); set_ch(0, 1'b0, 4'd0); tick();
      clear_inputs(); set_ch(2, 1'b0, 4'd0); tick();
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         dev_ack = 1'b1;
         dev_rdata = DW'(32'hA0 + i);
         #3;
         chk("order o_ch_ack", 64'(o_ack[0]), 64'(aseq[i]));
         chk("order fx o_ch_ack", 64'(o_ack[1]), 64'(aseq[i]));
         chk("order o_ch_data", 64'(o_chdata[0]), 64'(32'hA0 + i));
         tick();
      end

      // Asynchronous reset with two reads outstanding
      clear_inputs(); set_ch(0, 1'b0, 4'd0); tick();
      clear_inputs(); set_ch(1, 1'b0, 4'd0); tick();
      clear_inputs(); set_ch(0, 1'b0, 4'd0);
      dev_ack = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      chk("async o_request", 64'(o_req[0]), 64'd0);
      chk("async o_ch_ack", 64'(o_ack[0]), 64'd0);
      chk("async o_ch_busy", 64'(o_busy[0]), 64'h1);
      tick();
      tick();
      rst = 1'b0;
      set_ch(1, 1'b0, 4'd0);
      #3;
      chk("post o_ch_busy", 64'(o_busy[0]), 64'h2);
      chk("post o_ch_ack", 64'(o_ack[0]), 64'd0);
      chk("post o_request", 64'(o_req[0]), 64'd1);
      tick();

      // Randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         for (int k = 0; k < N; k++) begin
            ch_req[k] = ($urandom_range(0, 9) < 6);
            ch_wr[k]  = $urandom_range(0, 1);
            ch_bank[4*k +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            ch_addr[AW*k +: AW] = AW'($urandom);
            ch_data[DW*k +: DW] = $urandom;
         end
         dev_busy  = ($urandom_range(0, 9) < 3);
         dev_ack   = ($urandom_range(0, 9) < 4);
         dev_rdata = $urandom;
         tick();
      end

      clear_inputs();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
